// File: rtl/lcd_seq_ctrl.sv
// HD44780 script sequencer: ROM words -> RS/DB with E-strobe timing; optional LCD_SEQ_REPEAT_EN reruns the script after a gap.
// Latency: POWERON_CYC after reset, then 1 + SETUP_CYC + E_PULSE_CYC + wait cycles per word; all outputs registered.
// Backpressure: none; the panel is write-only and is paced purely by the cycle counters.
module lcd_seq_ctrl #(
    parameter logic [23:0] POWERON_CYC    = 24'd750000,
    parameter logic [23:0] SETUP_CYC      = 24'd2,
    parameter logic [23:0] E_PULSE_CYC    = 24'd25,
    parameter logic [23:0] CMD_WAIT_CYC   = 24'd2500,
    parameter logic [23:0] CLEAR_WAIT_CYC = 24'd82000,
    parameter logic [8:0]  END_CODE       = 9'h0FF
`ifdef LCD_SEQ_REPEAT_EN
    ,
    parameter logic [23:0] REPEAT_GAP_CYC = 24'd25000000
`endif
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       restart,
    output logic [6:0] romaddr,
    input  logic [8:0] romq,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_db,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        ST_POWERON,
        ST_FETCH,
        ST_SETUP,
        ST_PULSE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [6:0]  romaddr_q, romaddr_d;
    logic        rs_q, rs_d;
    logic [7:0]  db_q, db_d;
    logic        e_q, e_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        clear_cmd;
    logic [23:0] wait_cyc;

    // Clear display / return home (01h-03h) need the long execution wait.
    assign clear_cmd = !rs_q && (db_q[7:2] == 6'd0) && (db_q != 8'd0);
    assign wait_cyc  = clear_cmd ? CLEAR_WAIT_CYC : CMD_WAIT_CYC;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 24'd1;
        romaddr_d = romaddr_q;
        rs_d      = rs_q;
        db_d      = db_q;
        case (state_q)
            ST_POWERON: begin
                if (cnt_q == POWERON_CYC - 24'd1) begin
                    state_d = ST_FETCH;
                    cnt_d   = '0;
                end
            end
            ST_FETCH: begin
                cnt_d = '0;
                if (romq == END_CODE) begin
                    state_d = ST_DONE;
                end else begin
                    rs_d    = romq[8];
                    db_d    = romq[7:0];
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_CYC - 24'd1) begin
                    state_d = ST_PULSE;
                    cnt_d   = '0;
                end
            end
            ST_PULSE: begin
                if (cnt_q == E_PULSE_CYC - 24'd1) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (cnt_q == wait_cyc - 24'd1) begin
                    cnt_d = '0;
                    if (romaddr_q == 7'd127) begin
                        state_d = ST_DONE;
                    end else begin
                        romaddr_d = romaddr_q + 7'd1;
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
`ifdef LCD_SEQ_REPEAT_EN
                if (restart || (cnt_q == REPEAT_GAP_CYC - 24'd1)) begin
`else
                cnt_d = '0;
                if (restart) begin
`endif
                    state_d   = ST_FETCH;
                    romaddr_d = '0;
                    cnt_d     = '0;
                end
            end
            default: begin
                state_d = ST_POWERON;
                cnt_d   = '0;
            end
        endcase
        // Outputs are registered from the next state so they line up with the state they describe.
        e_d    = (state_d == ST_PULSE);
        busy_d = (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q   <= ST_POWERON;
            cnt_q     <= '0;
            romaddr_q <= '0;
            rs_q      <= 1'b0;
            db_q      <= '0;
            e_q       <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            romaddr_q <= romaddr_d;
            rs_q      <= rs_d;
            db_q      <= db_d;
            e_q       <= e_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign romaddr = romaddr_q;
    assign lcd_e   = e_q;
    assign lcd_rs  = rs_q;
    assign lcd_rw  = 1'b0;
    assign lcd_db  = db_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Bench for lcd_seq_ctrl: per-cycle comparison against a segment-based model of the LCD script timing.
module tb_lcd_seq_ctrl;

    localparam int T_PON = 4;
    localparam int T_SET = 1;
    localparam int T_PUL = 2;
    localparam int T_CMD = 3;
    localparam int T_CLR = 6;
    localparam int TAIL  = 3;

    logic       CLK;
    logic       RSTN;
    logic       restart;
    logic [6:0] romaddr;
    logic [8:0] romq;
    logic       lcd_e, lcd_rs, lcd_rw, busy, done;
    logic [7:0] lcd_db;
    logic [8:0] rom [128];

    assign romq = rom[romaddr];

    lcd_seq_ctrl #(
        .POWERON_CYC   (24'(T_PON)),
        .SETUP_CYC     (24'(T_SET)),
        .E_PULSE_CYC   (24'(T_PUL)),
        .CMD_WAIT_CYC  (24'(T_CMD)),
        .CLEAR_WAIT_CYC(24'(T_CLR)),
        .END_CODE      (9'h0FF)
`ifdef LCD_SEQ_REPEAT_EN
        ,
        .REPEAT_GAP_CYC(24'd5)
`endif
    ) dut (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .restart(restart),
        .romaddr(romaddr),
        .romq   (romq),
        .lcd_e  (lcd_e),
        .lcd_rs (lcd_rs),
        .lcd_rw (lcd_rw),
        .lcd_db (lcd_db),
        .busy   (busy),
        .done   (done)
    );

    typedef struct packed {
        logic       e;
        logic       rs;
        logic [7:0] db;
        logic [6:0] addr;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t       exp_q[$];
    int         exp_pulses;
    logic       last_rs;
    logic [7:0] last_db;
    int         checks   = 0;
    int         failures = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void push(input int n, input logic e, input logic rs, input logic [7:0] db,
                                 input logic [6:0] addr, input logic bsy, input logic dn);
        for (int k = 0; k < n; k++) exp_q.push_back({e, rs, db, addr, bsy, dn});
    endfunction

    // Expected waveform built word by word: fetch, setup, strobe, wait; then a few DONE cycles.
    function automatic void build(input bit pon, input logic rs0, input logic [7:0] db0,
                                  input int tail, input bit append);
        logic       rs;
        logic [7:0] db;
        logic [8:0] w;
        int         addr;
        if (!append) begin
            exp_q.delete();
            exp_pulses = 0;
        end
        rs = rs0;
        db = db0;
        addr = 0;
        if (pon) push(T_PON, 1'b0, rs, db, 7'd0, 1'b1, 1'b0);
        for (int guard = 0; guard < 200; guard++) begin
            push(1, 1'b0, rs, db, 7'(addr), 1'b1, 1'b0);
            w = rom[addr];
            if (w == 9'h0FF) break;
            rs = w[8];
            db = w[7:0];
            push(T_SET, 1'b0, rs, db, 7'(addr), 1'b1, 1'b0);
            push(T_PUL, 1'b1, rs, db, 7'(addr), 1'b1, 1'b0);
            exp_pulses++;
            push((!rs && db >= 8'd1 && db <= 8'd3) ? T_CLR : T_CMD, 1'b0, rs, db, 7'(addr), 1'b1, 1'b0);
            if (addr == 127) break;
            addr++;
        end
        push(tail, 1'b0, rs, db, 7'(addr), 1'b0, 1'b1);
        last_rs = rs;
        last_db = db;
    endfunction

    task automatic run_trace(input string name, input int restart_at, output int pulses);
        exp_t got;
        exp_t want;
        logic prev_e;
        pulses = 0;
        prev_e = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(negedge CLK);
            restart = 1'b0;
            got  = {lcd_e, lcd_rs, lcd_db, romaddr, busy, done};
            want = exp_q[i];
            checks++;
            if (got !== want || lcd_rw !== 1'b0) begin
                failures++;
                $display("FAIL %s cycle %0d: got e=%b rs=%b db=%h addr=%0d busy=%b done=%b rw=%b, want e=%b rs=%b db=%h addr=%0d busy=%b done=%b rw=0",
                         name, i, got.e, got.rs, got.db, got.addr, got.busy, got.done, lcd_rw,
                         want.e, want.rs, want.db, want.addr, want.busy, want.done);
            end
            if (lcd_e && !prev_e) pulses++;
            prev_e = lcd_e;
            if (i == restart_at) restart = 1'b1;
        end
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
    endtask

    task automatic rom_fill(input logic [8:0] w);
        for (int a = 0; a < 128; a++) rom[a] = w;
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        restart = 1'b0;
        rom_fill(9'h0FF);
        repeat (2) @(negedge CLK);
        checks++;
        if ({lcd_e, lcd_rs, lcd_rw, lcd_db, romaddr, busy, done} !== {3'b000, 8'h00, 7'd0, 2'b10}) begin
            failures++;
            $display("FAIL reset_values: got e=%b rs=%b rw=%b db=%h addr=%0d busy=%b done=%b, want 0 0 0 00 0 1 0",
                     lcd_e, lcd_rs, lcd_rw, lcd_db, romaddr, busy, done);
        end
    endtask

    task automatic test_poweron();
        int p;
        rom_fill(9'h0FF);
        rom[0] = 9'h038;
        do_reset();
        build(1'b1, 1'b0, 8'h00, TAIL, 1'b0);
        run_trace("poweron", -1, p);
        checks++;
        if (p !== 1) begin
            failures++;
            $display("FAIL poweron_pulses: got %0d want 1", p);
        end
    endtask

    task automatic test_clear_wait();
        int p;
        rom_fill(9'h0FF);
        rom[0] = 9'h001;
        rom[1] = 9'h141;
        do_reset();
        build(1'b1, 1'b0, 8'h00, TAIL, 1'b0);
        run_trace("clear_wait", -1, p);
        checks++;
        if (p !== 2) begin
            failures++;
            $display("FAIL clear_wait_pulses: got %0d want 2", p);
        end
    endtask

    task automatic test_full_script();
        int p;
        logic [8:0] w;
        rom_fill(9'h0FF);
        rom[0] = 9'h038; rom[1] = 9'h00F; rom[2] = 9'h001; rom[3] = 9'h150; rom[4] = 9'h16C;
        for (int a = 5; a < 29; a++) begin
            w = 9'($urandom_range(0, 511));
            if (w == 9'h0FF) w = 9'h0FE;
            rom[a] = w;
        end
        rom[12] = 9'h0C0;
        rom[20] = 9'h000;
        rom[28] = 9'h121;
        do_reset();
        build(1'b1, 1'b0, 8'h00, TAIL, 1'b0);
        run_trace("full_script", -1, p);
        checks++;
        if (p !== 29) begin
            failures++;
            $display("FAIL full_script_pulses: got %0d want 29", p);
        end
        checks++;
        if (romaddr !== 7'd29) begin
            failures++;
            $display("FAIL full_script_addr: got %0d want 29", romaddr);
        end
    endtask

    task automatic test_no_end();
        int p;
        rom_fill(9'h141);
        do_reset();
        build(1'b1, 1'b0, 8'h00, TAIL, 1'b0);
        run_trace("no_end", -1, p);
        checks++;
        if (p !== 128) begin
            failures++;
            $display("FAIL no_end_pulses: got %0d want 128", p);
        end
        checks++;
        if (romaddr !== 7'd127 || done !== 1'b1) begin
            failures++;
            $display("FAIL no_end_final: got addr=%0d done=%b want addr=127 done=1", romaddr, done);
        end
    endtask

    task automatic test_restart();
        int p;
        rom_fill(9'h0FF);
        rom[0] = 9'h038; rom[1] = 9'h00C; rom[2] = 9'h002;
        rom[3] = 9'h148; rom[4] = 9'h169; rom[5] = 9'h080;
        do_reset();
        build(1'b1, 1'b0, 8'h00, TAIL, 1'b0);
        run_trace("restart_mid", 8, p);
        checks++;
        if (p !== 6) begin
            failures++;
            $display("FAIL restart_mid_pulses: got %0d want 6", p);
        end
        restart = 1'b1;
        @(negedge CLK);
        build(1'b0, last_rs, last_db, TAIL, 1'b0);
        run_trace("restart_done", -1, p);
        checks++;
        if (p !== 6) begin
            failures++;
            $display("FAIL restart_done_pulses: got %0d want 6", p);
        end
    endtask

    task automatic test_reset_in_pulse();
        int p;
        rom_fill(9'h0FF);
        rom[0] = 9'h038; rom[1] = 9'h00C; rom[2] = 9'h006;
        do_reset();
        for (int n = 0; n < 60 && lcd_e !== 1'b1; n++) @(negedge CLK);
        checks++;
        if (lcd_e !== 1'b1) begin
            failures++;
            $display("FAIL reset_pulse_wait_e: got e=%b want 1 within 60 cycles", lcd_e);
        end
        RSTN = 1'b0;
        @(negedge CLK);
        checks++;
        if ({lcd_e, lcd_rs, lcd_db, romaddr, busy, done} !== {2'b00, 8'h00, 7'd0, 2'b10}) begin
            failures++;
            $display("FAIL reset_pulse_abort: got e=%b rs=%b db=%h addr=%0d busy=%b done=%b, want 0 0 00 0 1 0",
                     lcd_e, lcd_rs, lcd_db, romaddr, busy, done);
        end
        RSTN = 1'b1;
        build(1'b1, 1'b0, 8'h00, TAIL, 1'b0);
        run_trace("reset_pulse_rerun", -1, p);
        checks++;
        if (p !== 3) begin
            failures++;
            $display("FAIL reset_pulse_rerun_pulses: got %0d want 3", p);
        end
    endtask

    task automatic test_random();
        int p;
        int len;
        logic [8:0] w;
        for (int t = 0; t < 5; t++) begin
            rom_fill(9'h0FF);
            len = $urandom_range(1, 16);
            for (int a = 0; a < len; a++) begin
                if ($urandom_range(0, 3) == 0) w = 9'($urandom_range(1, 3));
                else w = 9'($urandom_range(0, 511));
                if (w == 9'h0FF) w = 9'h0FE;
                rom[a] = w;
            end
            do_reset();
            build(1'b1, 1'b0, 8'h00, TAIL, 1'b0);
            run_trace("random", -1, p);
            checks++;
            if (p !== len) begin
                failures++;
                $display("FAIL random_pulses: got %0d want %0d", p, len);
            end
        end
    endtask

`ifdef LCD_SEQ_REPEAT_EN
    task automatic test_repeat();
        int p;
        rom_fill(9'h0FF);
        rom[0] = 9'h001;
        rom[1] = 9'h141;
        do_reset();
        build(1'b1, 1'b0, 8'h00, 5, 1'b0);
        build(1'b0, last_rs, last_db, 2, 1'b1);
        run_trace("repeat", -1, p);
        checks++;
        if (p !== 4) begin
            failures++;
            $display("FAIL repeat_pulses: got %0d want 4", p);
        end
    endtask
`endif

    initial begin
        RSTN = 1'b0;
        restart = 1'b0;
        test_reset();
        test_poweron();
        test_clear_wait();
        test_full_script();
        test_no_end();
        test_restart();
        test_reset_in_pulse();
        test_random();
`ifdef LCD_SEQ_REPEAT_EN
        test_repeat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_seq_ctrl.md
Name: lcd_seq_ctrl

Overview:
- Sequencer that drives the character-LCD panel (HD44780-compatible, 8-bit bus, write-only) from the 9-bit LCD script ROM.
- Walks ROM addresses from 0, latches each word, and drives RS/DB with E-strobe timing plus post-write wait.
- Stops at the end code.
- Sits between the script ROM (combinational read) and the LCD pins; replaces hand-timed strobing in the top level.

Parameters:
- POWERON_CYC, 24'd750000, cycles of E-low wait after reset before first fetch (15 ms @ 50 MHz)
- SETUP_CYC, 24'd2, cycles RS/DB are stable before E rises (min 1)
- E_PULSE_CYC, 24'd25, cycles E is held high (min 1)
- CMD_WAIT_CYC, 24'd2500, cycles of E-low wait after a normal write (min 1)
- CLEAR_WAIT_CYC, 24'd82000, cycles of E-low wait after clear/home commands (min 1)
- END_CODE, 9'h0FF, ROM word that terminates the script; it is never written to the LCD

Ports:
- CLK  in  1  system clock
- RSTN  in  1  synchronous active-low reset
- restart  in  1  single-cycle pulse; reruns the script from address 0; honoured only in DONE
- romaddr  out  7  ROM address
- romq  in  9  ROM data, combinational from romaddr; bit8 = RS, bits7:0 = DB
- lcd_e  out  1  LCD enable strobe
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write; constant 0
- lcd_db  out  8  LCD data bus
- busy  out  1  high while the script is running
- done  out  1  high in DONE

Behaviour:
- Reset (RSTN=0 at a CLK edge):
  - State = POWERON, wait counter cleared.
  - romaddr = 0, lcd_e = 0, lcd_rs = 0, lcd_rw = 0, lcd_db = 0, busy = 1, done = 0.
  - Reset mid-operation aborts immediately with the same values; there is no partial strobe (E drops the next cycle).
- All outputs are registered. The wait counter is 24 bit. A state "lasting N cycles" means exactly N CLK cycles, then a transition.
- POWERON: lasts POWERON_CYC cycles, E = 0, then goes to FETCH.
- FETCH: lasts 1 cycle.
  - romaddr is stable; romq is sampled at the end of the cycle.
  - If romq == END_CODE, go to DONE; lcd_rs/lcd_db are unchanged.
  - Otherwise lcd_rs <= romq[8], lcd_db <= romq[7:0], go to SETUP.
- SETUP: lasts SETUP_CYC cycles, E = 0.
- PULSE: lasts E_PULSE_CYC cycles, E = 1. RS/DB do not change while E = 1 or in the cycle after E falls.
- WAIT: E = 0.
  - Lasts CLEAR_WAIT_CYC cycles if the latched RS = 0 and DB[7:2] = 0 and DB != 0 (codes 01h–03h).
  - Otherwise lasts CMD_WAIT_CYC cycles.
  - At the end: if romaddr == 127, go to DONE (no wrap); else romaddr += 1 and go to FETCH.
- Per-word period from FETCH to the next FETCH is 1 + SETUP_CYC + E_PULSE_CYC + wait.
- DONE:
  - busy = 0, done = 1, E = 0; lcd_rs/lcd_db hold their last values; romaddr holds.
  - restart = 1 sets romaddr = 0, busy = 1, done = 0, and goes to FETCH next cycle; there is no power-on wait.
- restart in any other state is ignored, and is not queued.
- A DB value of 00h with RS = 0 is written normally; only END_CODE terminates.

Optional Feature:
- Macro: LCD_SEQ_REPEAT_EN.
- Defined:
  - Adds parameter REPEAT_GAP_CYC (default 24'd25000000).
  - After REPEAT_GAP_CYC cycles in DONE, the block behaves as if restart were pulsed (romaddr = 0, FETCH). An explicit restart during the gap acts immediately.
  - done is high only during the gap.
- Undefined: DONE is terminal until restart or reset; no gap counter is synthesized.

Test Plan:
All tests use POWERON=4, SETUP=1, E_PULSE=2, CMD_WAIT=3, CLEAR_WAIT=6, and a behavioural ROM unless stated. Cycle numbers count from the first CLK edge with RSTN = 1 (cycle 0).
- Power-on timing:
  - Stimulus: ROM {038, 0FF}; release reset.
  - Response: E low through cycle 4; lcd_rs = 0 and lcd_db = 38h from cycle 5; E = 1 in cycles 6–7; the second FETCH in cycle 11; done = 1 and busy = 0 from cycle 12; exactly 1 E pulse.
- Clear wait:
  - Stimulus: ROM {001, 141, 0FF}.
  - Response: the gap between the 01h E falling edge and the next FETCH is 6 cycles; the gap after 141h is 3 cycles; lcd_rs = 1 and lcd_db = 41h for the second write; 2 pulses total.
- Full script:
  - Stimulus: ROM {038, 00F, 001, 150, 16C, …, 0C0, …, 121, 0FF at addr 29}.
  - Response: exactly 29 E pulses; the pulse sequence (RS, DB) matches addresses 0–28; romaddr = 29 in DONE; lcd_rw is 0 throughout.
- No end code:
  - Stimulus: ROM all 141h.
  - Response: 128 pulses; done asserts after address 127's WAIT; romaddr = 127; no wrap to 0.
- Restart:
  - Stimulus: restart pulse mid-script (ignored); then restart in DONE.
  - Response: the mid-script pulse has no effect on the pulse count. After the DONE restart, FETCH of address 0 occurs the next cycle, busy = 1 and done = 0, and no 4-cycle power-on wait occurs.
- Reset during PULSE:
  - Stimulus: assert RSTN = 0 while E = 1.
  - Response: E = 0, romaddr = 0, lcd_db = 0, busy = 1 the next cycle. After release, the power-on wait repeats in full.
  - With LCD_SEQ_REPEAT_EN and REPEAT_GAP = 5, the script reruns 5 cycles after done rises.
